// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: instruction-memory, redirect and decode-side signals of the fetch front end.
interface fetch_prefetch_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 10,
  parameter int DEPTH   = 4
);
  logic                     imem_req;
  logic [IMEM_AW-1:0]       imem_addr;
  logic [31:0]              imem_rdata;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_target;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [XLEN-1:0]          out_pc;
  logic [$clog2(DEPTH):0]   out_count;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_count,
    input  imem_rdata, redirect_valid, redirect_target, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_count,
    output imem_rdata, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential PC generator feeding a 1-cycle imem into a prefetch FIFO,
// with slots reserved for in-flight reads and a redirect that flushes everything.
module fetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h310,
  parameter int              IMEM_AW  = 10,
  parameter int              DEPTH    = 4
) (
  input logic             clk,
  input logic             rst_n,
  fetch_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW+1:0] sum_t;
  logic [XLEN-1:0] r_pc, r_pc_q;
  logic            r_req_q;
  logic [PW:0]     r_wptr, r_rptr;
  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pcs   [DEPTH];
  logic [PW:0]     w_count;
  logic            w_issue, w_push, w_pop;
  assign w_count = r_wptr - r_rptr;
  // The in-flight read counts against capacity so its return always has a slot.
  assign w_issue = rst_n & ~bus.redirect_valid & (sum_t'(w_count) + sum_t'(r_req_q) < sum_t'(DEPTH));
  assign w_push  = r_req_q & ~bus.redirect_valid;
  assign w_pop   = bus.out_valid & bus.out_ready;
  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc[IMEM_AW-1:0];
  assign bus.out_valid = w_count != '0;
  assign bus.out_count = w_count;
  assign bus.out_instr = r_instr[r_rptr[PW-1:0]];
  assign bus.out_pc    = r_pcs[r_rptr[PW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_pc_q  <= '0;
      r_req_q <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pcs[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_pc    <= {bus.redirect_target[XLEN-1:2], 2'b00};
      r_req_q <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_req_q <= w_issue;
      if (w_issue) begin
        r_pc   <= r_pc + XLEN'(4);
        r_pc_q <= r_pc;
      end
      if (w_push) begin
        r_instr[r_wptr[PW-1:0]] <= bus.imem_rdata;
        r_pcs[r_wptr[PW-1:0]]   <= r_pc_q;
        r_wptr                  <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
endmodule
